// File: rtl/delay_demux_pkg.sv
// Shared types and defaults for the delay demultiplexer.
// Holds the lane state encoding, default widths/delays and a counter sizing helper.
package delay_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10
    } lane_state_t;

    localparam int DEF_W    = 8;
    localparam int DEF_DLY0 = 3;
    localparam int DEF_DLY1 = 4;

    // Counter must hold DLY-1; keep at least one bit for DLY=1.
    function automatic int cnt_w(input int dly);
        return (dly > 1) ? $clog2(dly) : 1;
    endfunction

endpackage

// File: rtl/delay_demux_lane.sv
// One output lane: latches a word, holds it off DLY cycles, then presents it.
// Ports: clk, rst, load/load_data (accept), valid/ready/data (output), idle.
module delay_demux_lane
    import delay_demux_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int DLY = DEF_DLY0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         idle
);

    localparam int CW = cnt_w(DLY);

    if (DLY < 1) begin : g_bad_dly
        $error("delay_demux_lane: DLY must be >= 1");
    end

    lane_state_t   state;
    logic [CW-1:0] cnt;

    assign idle = (state == ST_IDLE);

    // Counter starts at DLY-1, so valid rises exactly DLY edges after load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        data  <= load_data;
                        cnt   <= CW'(DLY - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_VALID;
                        valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_VALID: begin
                    if (ready) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/delay_demux.sv
// Steers each accepted word to one of two independently delayed lanes.
// Ports: clk, rst, in_valid/in_ready/in_data/sel, out0_*, out1_* handshakes.
module delay_demux
    import delay_demux_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int DLY0 = DEF_DLY0,
    parameter int DLY1 = DEF_DLY1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         sel,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data
);

    logic idle0;
    logic idle1;
    logic load0;
    logic load1;

    // A lane that transfers this edge is still VALID, so it cannot reload here.
    assign in_ready = ~rst & (sel ? idle1 : idle0);
    assign load0    = in_valid & in_ready & ~sel;
    assign load1    = in_valid & in_ready & sel;

    delay_demux_lane #(.W(W), .DLY(DLY0)) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (in_data),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data),
        .idle      (idle0)
    );

    delay_demux_lane #(.W(W), .DLY(DLY1)) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data),
        .idle      (idle1)
    );

endmodule

// File: tb/tb_delay_demux.sv
// Directed bench for delay_demux with default parameters.
// Drives inputs 1ns after each rising edge and samples outputs there too.
module tb_delay_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    delay_demux dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel        (sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        sel        = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1;
        chk("rdy_in_rst", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst_v0", 32'(out0_valid), 32'd0);
        chk("rst_v1", 32'(out1_valid), 32'd0);
        chk("rst_d0", 32'(out0_data), 32'h00);
        chk("rst_d1", 32'(out1_data), 32'h00);
        chk("rdy_in_rst2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // Lane 0 latency with ready held high.
        in_valid   = 1'b1;
        sel        = 1'b0;
        in_data    = 8'hA5;
        out0_ready = 1'b1;
        #1;
        chk("a5_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("a5_v0_k", 32'(out0_valid), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("a5_v0", 32'(out0_valid), 32'(i == 3));
            chk("a5_v1", 32'(out1_valid), 32'd0);
        end
        chk("a5_d0", 32'(out0_data), 32'hA5);
        step();
        chk("a5_v0_drop", 32'(out0_valid), 32'd0);
        chk("a5_d0_keep", 32'(out0_data), 32'hA5);
        chk("a5_rdy_back", 32'(in_ready), 32'd1);

        // Lane 1 with ready low: hold word and block a second sel=1 word.
        out0_ready = 1'b0;
        sel        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h3C;
        step();
        in_data = 8'h77;
        #1;
        chk("3c_rdy_busy", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("3c_v1", 32'(out1_valid), 32'(i >= 4));
            chk("3c_rdy", 32'(in_ready), 32'd0);
            if (i >= 4) chk("3c_d1", 32'(out1_data), 32'h3C);
        end
        chk("3c_v0", 32'(out0_valid), 32'd0);
        out1_ready = 1'b1;
        step();
        chk("3c_v1_drop", 32'(out1_valid), 32'd0);
        chk("3c_d1_keep", 32'(out1_data), 32'h3C);
        chk("3c_rdy_rise", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("77_rdy_busy", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("77_v1", 32'(out1_valid), 32'(i == 4));
        end
        chk("77_d1", 32'(out1_data), 32'h77);
        step();
        chk("77_v1_drop", 32'(out1_valid), 32'd0);

        // Back-to-back accepts on different lanes.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        sel        = 1'b0;
        in_data    = 8'h11;
        step();
        sel     = 1'b1;
        in_data = 8'h22;
        #1;
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int j = 2; j <= 6; j++) begin
            step();
            chk("b2b_v0", 32'(out0_valid), 32'(j == 3));
            chk("b2b_v1", 32'(out1_valid), 32'(j == 5));
            if (j == 3) chk("b2b_d0", 32'(out0_data), 32'h11);
            if (j == 5) chk("b2b_d1", 32'(out1_data), 32'h22);
        end

        // Both lanes valid, simultaneous transfer.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        sel        = 1'b0;
        in_data    = 8'h55;
        step();
        sel     = 1'b1;
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("both_v0", 32'(out0_valid), 32'd1);
        chk("both_v1", 32'(out1_valid), 32'd1);
        chk("both_d0", 32'(out0_data), 32'h55);
        chk("both_d1", 32'(out1_data), 32'h66);
        sel = 1'b0;
        #1;
        chk("both_rdy0_busy", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        chk("both_v0_drop", 32'(out0_valid), 32'd0);
        chk("both_v1_drop", 32'(out1_valid), 32'd0);
        chk("both_rdy0", 32'(in_ready), 32'd1);
        sel = 1'b1;
        #1;
        chk("both_rdy1", 32'(in_ready), 32'd1);

        // Reset with lane 0 in WAIT and lane 1 in VALID.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        sel        = 1'b1;
        in_data    = 8'h99;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        sel      = 1'b0;
        in_data  = 8'h44;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_v1", 32'(out1_valid), 32'd1);
        chk("mid_v0", 32'(out0_valid), 32'd0);
        chk("mid_rdy0", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        rst        = 1'b1;
        #1;
        chk("mid_rdy_rst", 32'(in_ready), 32'd0);
        step();
        chk("mid_v0_rst", 32'(out0_valid), 32'd0);
        chk("mid_v1_rst", 32'(out1_valid), 32'd0);
        chk("mid_d0_rst", 32'(out0_data), 32'h00);
        chk("mid_d1_rst", 32'(out1_data), 32'h00);
        rst = 1'b0;
        #1;
        chk("mid_rdy0_rel", 32'(in_ready), 32'd1);
        sel = 1'b1;
        #1;
        chk("mid_rdy1_rel", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_v0_quiet", 32'(out0_valid), 32'd0);
            chk("mid_v1_quiet", 32'(out1_valid), 32'd0);
        end

        // Toggle sel with no valid: nothing leaves IDLE.
        in_valid = 1'b0;
        in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            #1;
            chk("tog_rdy", 32'(in_ready), 32'd1);
            step();
            chk("tog_v0", 32'(out0_valid), 32'd0);
            chk("tog_v1", 32'(out1_valid), 32'd0);
        end
        chk("tog_d0", 32'(out0_data), 32'h00);
        chk("tog_d1", 32'(out1_data), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
